// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: byte serializer, MSB first, with post-reset COMMA startup train and COMMA idle fill
module paralelo_serial_tx #(
    parameter logic [7:0] COMMA       = 8'hBC,
    parameter int         INIT_COMMAS = 6
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       sync_out,
    output logic       active_out
);
    localparam logic [0:0] INIT   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [3:0] comma_cnt;
    logic [0:0] state;
    logic       load;

    assign load       = (bit_cnt == 3'd7);
    assign data_out   = shreg[7];
    assign sync_out   = (bit_cnt == 3'd0);
    assign active_out = (state == ACTIVE);
    assign ready_out  = (state == ACTIVE) && load;

    // bit position within the current byte slot, free-running
    always_ff @(posedge clk_32f or negedge reset_L)
        if (!reset_L) bit_cnt <= 3'd0;
        else          bit_cnt <= bit_cnt + 3'd1;

    // shift out MSB first; on the last bit load the next byte (data, or COMMA when idle/training)
    always_ff @(posedge clk_32f or negedge reset_L)
        if (!reset_L)                     shreg <= COMMA;
        else if (!load)                   shreg <= {shreg[6:0], 1'b0};
        else if (state == ACTIVE && valid_in) shreg <= data_in;
        else                              shreg <= COMMA;

    // count startup commas (the reset-loaded one is comma 1) and go active after the last one is loaded
    always_ff @(posedge clk_32f or negedge reset_L)
        if (!reset_L) begin
            comma_cnt <= 4'd1;
            state     <= INIT;
        end else if (load && state == INIT) begin
            comma_cnt <= comma_cnt + 4'd1;
            if (comma_cnt + 4'd1 == 4'(INIT_COMMAS)) state <= ACTIVE;
        end
endmodule
